// File: rtl/led_scan_if.sv
// -----------------------------------------------------------------------------
// led_scan_if
// Groups the CPU-side load/brightness controls and the LED-side scan outputs
// of led_scan_driver into one bundle.
//
// Optional feature macro: LED_SCAN_BLINK_EN (adds blink_mask).
//
// Signals
//   load        1           capture strobe for load_data
//   load_data   8*DIGITS    byte d = load_data[8d+7:8d], 1 = LED lit
//   brightness  PWM_BITS    PWM duty, 0 = dark
//   blink_mask  DIGITS      (LED_SCAN_BLINK_EN only) digits that blink
//   seg_out     8           active-high segment data
//   digit_sel   DIGITS      one-hot active-high digit enable
//   frame_done  1           one-cycle pulse after the last digit slot
//
// Modports: master = controller/CPU side, slave = led_scan_driver.
// -----------------------------------------------------------------------------
interface led_scan_if #(
   parameter int DIGITS   = 4,
   parameter int PWM_BITS = 4
);
   logic                  load;
   logic [8*DIGITS-1:0]   load_data;
   logic [PWM_BITS-1:0]   brightness;
   logic [7:0]            seg_out;
   logic [DIGITS-1:0]     digit_sel;
   logic                  frame_done;
`ifdef LED_SCAN_BLINK_EN
   logic [DIGITS-1:0]     blink_mask;

   modport master (output load, load_data, brightness, blink_mask,
                   input  seg_out, digit_sel, frame_done);
   modport slave  (input  load, load_data, brightness, blink_mask,
                   output seg_out, digit_sel, frame_done);
`else
   modport master (output load, load_data, brightness,
                   input  seg_out, digit_sel, frame_done);
   modport slave  (input  load, load_data, brightness,
                   output seg_out, digit_sel, frame_done);
`endif
endinterface

// File: rtl/led_scan_driver.sv
// -----------------------------------------------------------------------------
// led_scan_driver
// Time-multiplexed LED display driver feeding inverting octal LED buffers.
// Display data is loaded into a shadow register and copied to the active
// register only at the frame wrap, so a frame never shows mixed data. Each
// digit gets a SCAN_DIV-cycle slot; the first PWM period of every slot is
// blanked (anti-ghosting), after that segments are PWM-dimmed by brightness.
// All outputs are registered and active-high.
//
// Optional feature macro: LED_SCAN_BLINK_EN adds bus.blink_mask and a 5-bit
// frame counter; masked digits are dark while frame_cnt[4] is set
// (16 frames on, 16 frames off).
//
// Parameters
//   DIGITS    number of digits (2..8)
//   SCAN_DIV  clk cycles per digit slot (multiple of 2**PWM_BITS, >= 2*2**PWM_BITS)
//   PWM_BITS  brightness resolution
//
// Ports
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    led_scan_if.slave (load, load_data, brightness, [blink_mask],
//          seg_out, digit_sel, frame_done); bus parameters must match.
// -----------------------------------------------------------------------------
module led_scan_driver #(
   parameter int DIGITS   = 4,
   parameter int SCAN_DIV = 1024,
   parameter int PWM_BITS = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   led_scan_if.slave  bus
);
   localparam int PWM_PERIOD = 2 ** PWM_BITS;
   localparam int CNT_W      = $clog2(SCAN_DIV);
   localparam int DIG_W      = $clog2(DIGITS);

   if (DIGITS < 2 || DIGITS > 8 || PWM_BITS < 1 ||
       SCAN_DIV < 2 * PWM_PERIOD || (SCAN_DIV % PWM_PERIOD) != 0) begin : g_bad_param
      $fatal(1, "led_scan_driver: illegal DIGITS/SCAN_DIV/PWM_BITS");
   end

   logic [CNT_W-1:0]       div_cnt;
   logic [DIG_W-1:0]       digit;
   logic [DIGITS-1:0][7:0] shadow;
   logic [DIGITS-1:0][7:0] active;
   logic                   slot_end;
   logic                   frame_wrap;
   logic                   on;
`ifdef LED_SCAN_BLINK_EN
   logic [4:0]             frame_cnt;
`endif

   assign slot_end   = (div_cnt == CNT_W'(SCAN_DIV - 1));
   assign frame_wrap = slot_end && (digit == DIG_W'(DIGITS - 1));

   // Output enable for the current state: PWM duty, minus the dead-time
   // period at the start of each slot, minus blinking digits.
   // NOTE: assign a default first so every path drives 'on' and no latch is inferred.
   always_comb begin
      on = (div_cnt[PWM_BITS-1:0] < bus.brightness) &&
           (div_cnt >= CNT_W'(PWM_PERIOD));
`ifdef LED_SCAN_BLINK_EN
      if (bus.blink_mask[digit] && frame_cnt[4]) on = 1'b0;
`endif
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt        <= '0;
         digit          <= '0;
         // NOTE: the display registers are reset on purpose so a reset
         // always clears the display; they are flops, not RAM.
         shadow         <= '0;
         active         <= '0;
         bus.seg_out    <= '0;
         bus.digit_sel  <= '0;
         bus.frame_done <= 1'b0;
`ifdef LED_SCAN_BLINK_EN
         frame_cnt      <= '0;
`endif
      end else begin
         div_cnt <= slot_end ? '0 : div_cnt + CNT_W'(1);
         if (slot_end)
            digit <= (digit == DIG_W'(DIGITS - 1)) ? '0 : digit + DIG_W'(1);

         if (bus.load) shadow <= bus.load_data;

         // A load in the wrap cycle bypasses the shadow so it shows without
         // a frame of lag.
         if (frame_wrap) active <= bus.load ? bus.load_data : shadow;

`ifdef LED_SCAN_BLINK_EN
         if (frame_wrap) frame_cnt <= frame_cnt + 5'd1;
`endif

         bus.frame_done <= frame_wrap;
         bus.seg_out    <= on ? active[digit] : 8'h00;
         bus.digit_sel  <= on ? (DIGITS'(1) << digit) : '0;
      end
   end
endmodule

// File: tb/tb_led_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_led_scan_driver
// Directed bench for led_scan_driver with DIGITS=4, SCAN_DIV=32, PWM_BITS=4
// (128-cycle frames). Each frame is stepped edge by edge and every output is
// compared with values derived from the frame offset, brightness and the data
// expected on the display. Build with +define+LED_SCAN_BLINK_EN to also cover
// blinking.
// -----------------------------------------------------------------------------
module tb_led_scan_driver;
   localparam int DIGITS   = 4;
   localparam int SCAN_DIV = 32;
   localparam int PWM_BITS = 4;
   localparam int FRAME    = DIGITS * SCAN_DIV;

   logic clk = 1'b0;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   led_scan_if #(.DIGITS(DIGITS), .PWM_BITS(PWM_BITS)) bus ();

   led_scan_driver #(
      .DIGITS   (DIGITS),
      .SCAN_DIV (SCAN_DIV),
      .PWM_BITS (PWM_BITS)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // One clock edge, then sample 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Runs one aligned frame. Offset i is the state (digit i/32, div_cnt i%32)
   // consumed by edge i, whose registered result is visible right after it.
   task automatic run_frame(input string name, input logic [3:0] br,
                            input logic [31:0] data, input logic [3:0] blank,
                            input int load_at, input logic [31:0] load_val,
                            input int load_at2, input logic [31:0] load_val2,
                            input int exp_on);
      int on_cnt;
      on_cnt = 0;
      bus.brightness = br;
      for (int i = 0; i < FRAME; i++) begin
         int       div;
         int       d;
         logic     on;
         logic [7:0] exp_seg;
         logic [3:0] exp_sel;
         if (i == load_at) begin
            bus.load = 1'b1; bus.load_data = load_val;
         end else if (i == load_at2) begin
            bus.load = 1'b1; bus.load_data = load_val2;
         end else begin
            bus.load = 1'b0;
         end
         step();
         div     = i % SCAN_DIV;
         d       = i / SCAN_DIV;
         on      = ((div % 16) < int'(br)) && (div >= 16) && !blank[d];
         exp_seg = on ? data[8*d +: 8] : 8'h00;
         exp_sel = on ? (4'b0001 << d) : 4'b0000;
         if (bus.digit_sel != 4'b0000) on_cnt++;
         check($sformatf("%s i%0d seg_out", name, i), 32'(bus.seg_out), 32'(exp_seg));
         check($sformatf("%s i%0d digit_sel", name, i), 32'(bus.digit_sel), 32'(exp_sel));
         check($sformatf("%s i%0d frame_done", name, i), 32'(bus.frame_done),
               32'(i == FRAME - 1));
      end
      bus.load = 1'b0;
      check($sformatf("%s on_cycles", name), 32'(on_cnt), 32'(exp_on));
   endtask

   initial begin
      bus.load       = 1'b0;
      bus.load_data  = '0;
      bus.brightness = 4'hF;
`ifdef LED_SCAN_BLINK_EN
      bus.blink_mask = '0;
`endif
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      repeat (3) step();
      check("reset seg_out", 32'(bus.seg_out), 32'h0);
      check("reset digit_sel", 32'(bus.digit_sel), 32'h0);
      check("reset frame_done", 32'(bus.frame_done), 32'h0);
      rst_n = 1'b1;

      // Frame 0: display blank; mid-frame load is only shadowed.
      run_frame("f0", 4'hF, 32'h0, 4'b0000, 64, 32'h8142_A55A, -1, 32'h0, 60);
      // Frame 1: previous load shown; back-to-back loads, the last one wins.
      run_frame("f1", 4'hF, 32'h8142_A55A, 4'b0000, 10, 32'hDEAD_BEEF, 11,
                32'h0102_0304, 60);
      // Frame 2: brightness 4 -> 4 of 16 cycles per slot; load in wrap cycle.
      run_frame("f2", 4'h4, 32'h0102_0304, 4'b0000, FRAME - 1, 32'h1122_3344,
                -1, 32'h0, 16);
      // Frame 3: wrap-cycle load shown with no frame lag.
      run_frame("f3", 4'hF, 32'h1122_3344, 4'b0000, -1, 32'h0, -1, 32'h0, 60);
      // Frame 4: brightness 0 keeps everything dark.
      run_frame("f4", 4'h0, 32'h1122_3344, 4'b0000, -1, 32'h0, -1, 32'h0, 0);

      // Reset in the middle of digit 0's lit window.
      bus.brightness = 4'hF;
      repeat (20) step();
      check("pre-reset seg_out", 32'(bus.seg_out), 32'h44);
      check("pre-reset digit_sel", 32'(bus.digit_sel), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      check("async reset seg_out", 32'(bus.seg_out), 32'h0);
      check("async reset digit_sel", 32'(bus.digit_sel), 32'h0);
`ifdef LED_SCAN_BLINK_EN
      bus.blink_mask = 4'b0010;
`endif
      @(posedge clk);
      #1 rst_n = 1'b1;

      // After reset: digit 0 first, active and shadow both cleared.
      run_frame("r0", 4'hF, 32'h0, 4'b0000, 0, 32'hFFFF_FFFF, -1, 32'h0, 60);
      run_frame("r1", 4'hF, 32'hFFFF_FFFF, 4'b0000, 0, 32'h0, -1, 32'h0, 60);
`ifdef LED_SCAN_BLINK_EN
      // Frames 2..33 since reset: digit 1 dark during frames 16..31.
      for (int f = 2; f < 34; f++) begin
         logic blink_off;
         blink_off = (f % 32) >= 16;
         run_frame($sformatf("b%0d", f), 4'hF, 32'h0, blink_off ? 4'b0010 : 4'b0000,
                   -1, 32'h0, -1, 32'h0, blink_off ? 45 : 60);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
